// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - pong match controller: scores, serve timing, win detection, game-over.
// Optional GAME_CTRL_WIN_BY_TWO_EN: winner must lead every other player by two points.
module game_ctrl #(
    parameter int N_PLAYERS    = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60,
    localparam int PW          = $clog2(N_PLAYERS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           vsync,
    input  logic                           start,
    input  logic [N_PLAYERS-1:0]           miss,
    input  logic [PW-1:0]                  last_hit,
    output logic [N_PLAYERS*SCORE_W-1:0]   score,
    output logic [N_PLAYERS-1:0]           score_pulse,
    output logic                           ball_reset,
    output logic                           ball_run,
    output logic [PW-1:0]                  serve_dir,
    output logic                           game_over,
    output logic [PW-1:0]                  winner
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
    localparam int                 CNT_W     = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0]   SERVE_END = CNT_W'(SERVE_FRAMES);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, CHECK, OVER} state_t;

    state_t               state, state_nxt;
    logic                 vsync_q, start_q;
    logic [N_PLAYERS-1:0] miss_q;
    logic                 frame_tick, start_rise;
    logic [N_PLAYERS-1:0] miss_rise;
    logic [SCORE_W-1:0]   scores [N_PLAYERS];
    logic [CNT_W-1:0]     serve_cnt;
    logic [PW-1:0]        loser, scorer, scorer_q;
    logic [SCORE_W-1:0]   sel_score;
    logic                 win_cond;
    logic                 clr, hit, win;

    assign frame_tick = vsync_q & ~vsync;
    assign start_rise = start & ~start_q;
    assign miss_rise  = miss & ~miss_q;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_score
        assign score[g*SCORE_W +: SCORE_W] = scores[g];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b1;
            start_q <= 1'b0;
            miss_q  <= '0;
        end else begin
            vsync_q <= vsync;
            start_q <= start;
            miss_q  <= miss;
        end
    end

    // Lowest missing goal loses; a self-hit or out-of-range last_hit credits the next player.
    always_comb begin
        loser = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (miss_rise[i]) loser = PW'(i);
        end
        if (last_hit != loser && int'(last_hit) < N_PLAYERS) scorer = last_hit;
        else if (int'(loser) == N_PLAYERS - 1)               scorer = '0;
        else                                                 scorer = loser + PW'(1);
    end

    always_comb begin
        sel_score = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (PW'(i) == scorer_q) sel_score = scores[i];
        end
    end

`ifdef GAME_CTRL_WIN_BY_TWO_EN
    logic lead_ok;
    always_comb begin
        lead_ok = 1'b1;
        for (int j = 0; j < N_PLAYERS; j++) begin
            if (PW'(j) != scorer_q &&
                {1'b0, sel_score} < ({1'b0, scores[j]} + (SCORE_W + 1)'(2)))
                lead_ok = 1'b0;
        end
        // A saturated score always wins so the match cannot stall.
        win_cond = (sel_score == SCORE_MAX) || (sel_score >= WIN_VAL && lead_ok);
    end
`else
    assign win_cond = (sel_score >= WIN_VAL);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        hit       = 1'b0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    clr       = 1'b1;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (serve_cnt == SERVE_END) state_nxt = PLAY;
            end
            PLAY: begin
                if (|miss_rise) begin
                    hit       = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (win_cond) begin
                    win       = 1'b1;
                    state_nxt = OVER;
                end else begin
                    state_nxt = SERVE;
                end
            end
            OVER: begin
                if (start_rise) begin
                    clr       = 1'b1;
                    state_nxt = SERVE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PLAYERS; i++) scores[i] <= '0;
            score_pulse <= '0;
            ball_reset  <= 1'b1;
            ball_run    <= 1'b0;
            serve_dir   <= '0;
            game_over   <= 1'b0;
            winner      <= '0;
            scorer_q    <= '0;
            serve_cnt   <= '0;
        end else begin
            ball_run   <= (state_nxt == PLAY);
            ball_reset <= (state_nxt != PLAY);
            for (int i = 0; i < N_PLAYERS; i++) begin
                score_pulse[i] <= hit && (PW'(i) == scorer);
                if (clr)
                    scores[i] <= '0;
                else if (hit && PW'(i) == scorer && scores[i] != SCORE_MAX)
                    scores[i] <= scores[i] + SCORE_W'(1);
            end
            if (clr) begin
                serve_dir <= '0;
                game_over <= 1'b0;
                winner    <= '0;
            end
            if (hit) begin
                serve_dir <= loser;
                scorer_q  <= scorer;
            end
            if (win) begin
                game_over <= 1'b1;
                winner    <= scorer_q;
            end
            // Counter restarts on every entry into SERVE and stops at the target.
            if (state_nxt == SERVE && state != SERVE)
                serve_cnt <= '0;
            else if (state == SERVE && frame_tick && serve_cnt != SERVE_END)
                serve_cnt <= serve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed scoreboard bench for game_ctrl (3 players, win at 3, 2-frame serve).
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic        start;
    logic [2:0]  miss;
    logic [1:0]  last_hit;
    logic [11:0] score;
    logic [2:0]  score_pulse;
    logic        ball_reset;
    logic        ball_run;
    logic [1:0]  serve_dir;
    logic        game_over;
    logic [1:0]  winner;

    game_ctrl #(
        .N_PLAYERS   (3),
        .SCORE_W     (4),
        .WIN_SCORE   (3),
        .SERVE_FRAMES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .start      (start),
        .miss       (miss),
        .last_hit   (last_hit),
        .score      (score),
        .score_pulse(score_pulse),
        .ball_reset (ball_reset),
        .ball_run   (ball_run),
        .serve_dir  (serve_dir),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] sc;
        logic [2:0]  pulse;
        logic [1:0]  dir;
        logic        go;
        logic [1:0]  win;
    } exp_t;

    exp_t sb[$];
    int   ms[3];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic over     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pack_scores();
        return {ms[2][3:0], ms[1][3:0], ms[0][3:0]};
    endfunction

    function automatic logic model_win(input int s);
        logic lead;
        lead = 1'b1;
        for (int j = 0; j < 3; j++)
            if (j != s && ms[s] < ms[j] + 2) lead = 1'b0;
`ifdef GAME_CTRL_WIN_BY_TWO_EN
        return (ms[s] == 15) || (ms[s] >= 3 && lead);
`else
        return ms[s] >= 3;
`endif
    endfunction

    task automatic frame();
        @(negedge clk) vsync = 1'b0;
        @(negedge clk);
        @(negedge clk) vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_serve(input string tag);
        int frames;
        frames = 0;
        while (ball_run !== 1'b1 && frames < 8) begin
            frame();
            frames++;
        end
        check(tag, frames, 2);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        for (int i = 0; i < 3; i++) ms[i] = 0;
        check({tag, "_score"}, score, pack_scores());
        check({tag, "_ball_reset"}, ball_reset, 1);
        check({tag, "_game_over"}, game_over, 0);
        check({tag, "_serve_dir"}, serve_dir, 0);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic point(input logic [2:0] mv, input logic [1:0] lh, input string tag);
        exp_t       e;
        int         l, s;
        logic [2:0] p;
        wait_serve({tag, "_serve"});
        l = 0;
        for (int i = 2; i >= 0; i--) if (mv[i]) l = i;
        if (int'(lh) != l && lh < 3) s = int'(lh);
        else                         s = (l + 1) % 3;
        if (ms[s] < 15) ms[s]++;
        p = 3'b001;
        p = p << s;
        e.sc = pack_scores(); e.pulse = p; e.dir = 2'(l);
        e.go = model_win(s);  e.win = 2'(s);
        sb.push_back(e);
        @(negedge clk) begin miss = mv; last_hit = lh; end
        @(posedge clk) #1;
        e = sb.pop_front();
        check({tag, "_score"}, score, e.sc);
        check({tag, "_pulse"}, score_pulse, e.pulse);
        check({tag, "_serve_dir"}, serve_dir, e.dir);
        check({tag, "_ball_run"}, ball_run, 0);
        @(negedge clk) miss = 3'b000;
        @(posedge clk) #1;
        check({tag, "_pulse_end"}, score_pulse, 0);
        check({tag, "_game_over"}, game_over, e.go);
        if (e.go) check({tag, "_winner"}, winner, e.win);
        over = e.go;
    endtask

    initial begin
        reset_n = 1'b0; vsync = 1'b1; start = 1'b0; miss = '0; last_hit = '0;
        repeat (3) @(negedge clk);
        check("rst_score", score, 0);
        check("rst_pulse", score_pulse, 0);
        check("rst_ball_reset", ball_reset, 1);
        check("rst_ball_run", ball_run, 0);
        check("rst_serve_dir", serve_dir, 0);
        check("rst_game_over", game_over, 0);
        check("rst_winner", winner, 0);
        reset_n = 1'b1;
        @(negedge clk);
        frame();
        check("idle_no_run", ball_run, 0);

        do_start("start1");
        check("serve_hold", ball_run, 0);
        point(3'b010, 2'd0, "p1_hit0_miss1");
        point(3'b011, 2'd2, "p2_double_miss");
        point(3'b010, 2'd1, "p3_self_hit");
        point(3'b100, 2'd3, "p4_bad_last_hit");
        for (int k = 0; k < 4 && !over; k++) point(3'b001, 2'd2, "p_win_run");
        check("match_over", game_over, 1);
        check("winner_p2", winner, 2);

        @(negedge clk) begin miss = 3'b001; last_hit = 2'd1; end
        @(posedge clk) #1;
        check("over_miss_score", score, pack_scores());
        check("over_miss_pulse", score_pulse, 0);
        check("over_hold", game_over, 1);
        @(negedge clk) miss = 3'b000;

        do_start("restart");
        point(3'b010, 2'd0, "r1");
        point(3'b001, 2'd1, "r2");
        wait_serve("pre_reset_serve");

        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_score", score, 0);
        check("arst_pulse", score_pulse, 0);
        check("arst_ball_reset", ball_reset, 1);
        check("arst_ball_run", ball_run, 0);
        check("arst_serve_dir", serve_dir, 0);
        check("arst_game_over", game_over, 0);
        check("arst_winner", winner, 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) frame();
        check("post_rst_idle", ball_run, 0);
        do_start("resume");
        wait_serve("resume_serve");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
